pe_param: RTL and testbench

Parametrised row-stationary processing element for the PE array; it is the successor of the fixed 8-bit, 4-lane PE. It loads filters, a sliding ifmap window and input psums over valid/ready links. It then runs one MAC per cycle and streams output psums. New relative to the previous generation:
- programmable stride (1..4) and filter width (1..4);
- programmable ifmap zero-point;
- depthwise filter loading sized to q·rs;
- optional ReLU on output;
- busy/done status.

---
 rtl/pe_param_if.sv | 35 +++
 rtl/pe_param.sv | 169 ++++++++++++++++
 tb/tb_pe_param.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_param_if.sv
// pe_param_if: control, status and valid/ready links between the PE array fabric and one pe_param.
interface pe_param_if #(
    parameter int ELEM_BITS   = 8,
    parameter int LANES       = 4,
    parameter int PSUM_BITS   = 32,
    parameter int CONFIG_SIZE = 16
);
    logic                       PE_en;
    logic [CONFIG_SIZE-1:0]     i_config;
    logic [ELEM_BITS-1:0]       ifmap_zp;
    logic [LANES*ELEM_BITS-1:0] ifmap;
    logic [LANES*ELEM_BITS-1:0] filter;
    logic [PSUM_BITS-1:0]       ipsum;
    logic [PSUM_BITS-1:0]       opsum;
    logic                       ifmap_valid;
    logic                       filter_valid;
    logic                       ipsum_valid;
    logic                       opsum_ready;
    logic                       ifmap_ready;
    logic                       filter_ready;
    logic                       ipsum_ready;
    logic                       opsum_valid;
    logic                       busy;
    logic                       done;
    modport master (
        output PE_en, i_config, ifmap_zp, ifmap, filter, ipsum,
        output ifmap_valid, filter_valid, ipsum_valid, opsum_ready,
        input  ifmap_ready, filter_ready, ipsum_ready, opsum_valid, opsum, busy, done
    );
    modport slave (
        input  PE_en, i_config, ifmap_zp, ifmap, filter, ipsum,
        input  ifmap_valid, filter_valid, ipsum_valid, opsum_ready,
        output ifmap_ready, filter_ready, ipsum_ready, opsum_valid, opsum, busy, done
    );
endinterface

// File: rtl/pe_param.sv
// pe_param: row-stationary PE with programmable stride, filter width, ifmap zero-point,
// depthwise filters and optional ReLU; one MAC per cycle between load and drain phases.
module pe_param #(
    parameter int ELEM_BITS   = 8,
    parameter int LANES       = 4,
    parameter int PSUM_BITS   = 32,
    parameter int CONFIG_SIZE = 16
) (
    input logic        clk,
    input logic        rst,
    pe_param_if.slave  bus
);
    localparam int FN = 64;
    localparam int WN = 16;
    localparam int PN = 4;
    localparam int PW = 2 * ELEM_BITS + 1;
    typedef enum logic [2:0] {IDLE, READ_FILTER, READ_IFMAP, READ_IPSUM, CONV, WRITE_OPSUM} state_t;
    state_t                      state_q, state_d;
    logic [CONFIG_SIZE-1:0]      cfg_q, cfg_d;
    logic [ELEM_BITS-1:0]        zp_q, zp_d;
    logic [6:0]                  cnt_q, cnt_d;
    logic [4:0]                  col_q, col_d;
    logic [3:0]                  wi_q, wi_d;
    logic [1:0]                  pi_q, pi_d;
    logic                        done_q, done_d;
    logic signed [ELEM_BITS-1:0] filt_q [FN];
    logic signed [ELEM_BITS-1:0] filt_d [FN];
    logic signed [ELEM_BITS:0]   win_q [WN];
    logic signed [ELEM_BITS:0]   win_d [WN];
    logic signed [PSUM_BITS-1:0] psum_q [PN];
    logic signed [PSUM_BITS-1:0] psum_d [PN];
    logic [2:0]                  q_n, p_n, u_n, rs_n;
    logic                        dw, relu, last_col, unused;
    logic [6:0]                  qrs, uq, n_fb, n_ib, n_ps, n_mac, fbase, s_ifm, wbase;
    logic signed [PW-1:0]        prod;
    assign q_n      = {1'b0, cfg_q[1:0]} + 3'd1;
    assign p_n      = {1'b0, cfg_q[3:2]} + 3'd1;
    assign u_n      = {1'b0, cfg_q[10:9]} + 3'd1;
    assign rs_n     = {1'b0, cfg_q[12:11]} + 3'd1;
    assign dw       = cfg_q[13];
    assign relu     = cfg_q[14];
    assign unused   = cfg_q[CONFIG_SIZE-1];
    assign last_col = col_q == cfg_q[8:4];
    assign qrs      = {4'b0, q_n} * {4'b0, rs_n};
    assign uq       = {4'b0, u_n} * {4'b0, q_n};
    assign n_fb     = dw ? {4'b0, rs_n} : {4'b0, p_n} * {4'b0, rs_n};
    assign n_ib     = (col_q == '0) ? {4'b0, rs_n} : {4'b0, u_n};
    assign n_ps     = dw ? {4'b0, q_n} : {4'b0, p_n};
    assign n_mac    = dw ? qrs : {4'b0, p_n} * qrs;
    // filter beat b holds tap (m, s) with b = m*rs + s, so its base slot is simply b*q
    assign fbase    = cnt_q * {4'b0, q_n};
    // after the first column the window already holds rs-U taps; new beats append behind them
    assign s_ifm    = (col_q == '0) ? cnt_q : {4'b0, rs_n} - {4'b0, u_n} + cnt_q;
    assign wbase    = s_ifm * {4'b0, q_n};
    assign prod     = PW'(filt_q[cnt_q[5:0]]) * PW'(win_q[wi_q]);
    assign bus.filter_ready = state_q == READ_FILTER;
    assign bus.ifmap_ready  = state_q == READ_IFMAP;
    assign bus.ipsum_ready  = state_q == READ_IPSUM;
    assign bus.opsum_valid  = state_q == WRITE_OPSUM;
    assign bus.busy         = state_q != IDLE;
    assign bus.done         = done_q;
    assign bus.opsum        = (state_q == WRITE_OPSUM && !(relu && psum_q[cnt_q[1:0]][PSUM_BITS-1]))
                              ? psum_q[cnt_q[1:0]] : '0;
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        zp_d    = zp_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        wi_d    = wi_q;
        pi_d    = pi_q;
        done_d  = 1'b0;
        filt_d  = filt_q;
        win_d   = win_q;
        psum_d  = psum_q;
        case (state_q)
            IDLE: begin
                filt_d = '{default: '0};
                win_d  = '{default: '0};
                psum_d = '{default: '0};
                cnt_d  = '0;
                col_d  = '0;
                wi_d   = '0;
                pi_d   = '0;
                if (bus.PE_en) begin
                    cfg_d   = bus.i_config;
                    zp_d    = bus.ifmap_zp;
                    state_d = READ_FILTER;
                end
            end
            READ_FILTER: if (bus.filter_valid) begin
                for (int c = 0; c < 4; c++)
                    if (c < int'(q_n)) filt_d[fbase[5:0] + 6'(c)] = bus.filter[c*ELEM_BITS +: ELEM_BITS];
                cnt_d   = (cnt_q == n_fb - 7'd1) ? '0 : cnt_q + 7'd1;
                state_d = (cnt_q == n_fb - 7'd1) ? READ_IFMAP : READ_FILTER;
            end
            READ_IFMAP: if (bus.ifmap_valid) begin
                for (int c = 0; c < 4; c++)
                    if (c < int'(q_n))
                        win_d[wbase[3:0] + 4'(c)] = {1'b0, bus.ifmap[c*ELEM_BITS +: ELEM_BITS]} - {1'b0, zp_q};
                cnt_d   = (cnt_q == n_ib - 7'd1) ? '0 : cnt_q + 7'd1;
                state_d = (cnt_q == n_ib - 7'd1) ? READ_IPSUM : READ_IFMAP;
            end
            READ_IPSUM: if (bus.ipsum_valid) begin
                psum_d[cnt_q[1:0]] = bus.ipsum;
                cnt_d   = (cnt_q == n_ps - 7'd1) ? '0 : cnt_q + 7'd1;
                wi_d    = '0;
                pi_d    = '0;
                state_d = (cnt_q == n_ps - 7'd1) ? CONV : READ_IPSUM;
            end
            CONV: begin
                psum_d[pi_q] = psum_q[pi_q] + PSUM_BITS'(prod);
                // normal mode walks the window once per output channel; depthwise walks it once, rotating channels
                if (dw) begin
                    wi_d = wi_q + 4'd1;
                    pi_d = ({1'b0, pi_q} == q_n - 3'd1) ? '0 : pi_q + 2'd1;
                end else begin
                    wi_d = ({3'b0, wi_q} == qrs - 7'd1) ? '0 : wi_q + 4'd1;
                    pi_d = ({3'b0, wi_q} == qrs - 7'd1) ? pi_q + 2'd1 : pi_q;
                end
                cnt_d   = (cnt_q == n_mac - 7'd1) ? '0 : cnt_q + 7'd1;
                state_d = (cnt_q == n_mac - 7'd1) ? WRITE_OPSUM : CONV;
            end
            WRITE_OPSUM: if (bus.opsum_ready) begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == n_ps - 7'd1) begin
                    cnt_d = '0;
                    if (last_col) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        for (int k = 0; k < WN; k++)
                            win_d[k] = (7'(k) + uq < 7'(WN)) ? win_q[4'(7'(k) + uq)] : '0;
                        col_d   = col_q + 5'd1;
                        state_d = READ_IFMAP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            zp_q    <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            wi_q    <= '0;
            pi_q    <= '0;
            done_q  <= 1'b0;
            filt_q  <= '{default: '0};
            win_q   <= '{default: '0};
            psum_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            zp_q    <= zp_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            wi_q    <= wi_d;
            pi_q    <= pi_d;
            done_q  <= done_d;
            filt_q  <= filt_d;
            win_q   <= win_d;
            psum_q  <= psum_d;
        end
    end
endmodule

// File: tb/tb_pe_param.sv
// tb_pe_param: directed and randomized jobs for pe_param, checked against a window-position
// model (opsum = ipsum + sum of filter x (ifmap - zp) over the column's absolute ifmap span).
module tb_pe_param;
    localparam int EB = 8;
    localparam int LN = 4;
    localparam int PB = 32;
    localparam int CS = 16;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    pe_param_if #(.ELEM_BITS(EB), .LANES(LN), .PSUM_BITS(PB), .CONFIG_SIZE(CS)) bus ();
    pe_param #(.ELEM_BITS(EB), .LANES(LN), .PSUM_BITS(PB), .CONFIG_SIZE(CS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    int fcount = 0;
    int qn, pn, fn, un, rsn, dwn, relun, zpn;
    logic [LN*EB-1:0] fb [16];
    logic [LN*EB-1:0] xb [128];
    logic [PB-1:0]    ip [32][4];
    logic [PB-1:0]    obs [$];
    always @(posedge clk) if (bus.filter_valid && bus.filter_ready) fcount++;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [PB-1:0] o, input logic [PB-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask
    function automatic int lane_s(input logic [LN*EB-1:0] b, input int c);
        return int'($signed(b[c*EB +: EB]));
    endfunction
    function automatic int lane_u(input logic [LN*EB-1:0] b, input int c);
        return int'(b[c*EB +: EB]);
    endfunction
    // column col covers absolute ifmap positions col*U .. col*U+rs-1 of the beat stream
    function automatic logic [PB-1:0] model(input int col, input int j);
        int acc = int'(ip[col][j]);
        for (int s = 0; s < rsn; s++)
            for (int c = 0; c < qn; c++) begin
                int w;
                if (dwn != 0 && c != j) continue;
                w = (dwn != 0) ? lane_s(fb[s], c) : lane_s(fb[j*rsn + s], c);
                acc += w * (lane_u(xb[col*un + s], c) - zpn);
            end
        if (relun != 0 && acc < 0) acc = 0;
        return acc;
    endfunction
    function automatic logic rdy(input int kind);
        return (kind == 0) ? bus.filter_ready : (kind == 1) ? bus.ifmap_ready : bus.ipsum_ready;
    endfunction
    task automatic set_cfg(input int q, input int p, input int f, input int u, input int rs,
                           input int dw, input int relu, input int zp);
        qn = q; pn = p; fn = f; un = u; rsn = rs; dwn = dw; relun = relu; zpn = zp;
    endtask
    task automatic fill_rand();
        for (int i = 0; i < 16; i++) fb[i] = $urandom;
        for (int i = 0; i < 128; i++) xb[i] = $urandom;
        for (int i = 0; i < 32; i++) for (int j = 0; j < 4; j++) ip[i][j] = $urandom;
    endtask
    task automatic start_job();
        bus.i_config = {1'b0, relun[0], dwn[0], 2'(rsn - 1), 2'(un - 1), 5'(fn), 2'(pn - 1), 2'(qn - 1)};
        bus.ifmap_zp = 8'(zpn);
        bus.PE_en = 1'b1;
        @(negedge clk);
        bus.PE_en = 1'b0;
        chk("start_busy", {31'b0, bus.busy}, 1);
        chk("start_filter_ready", {31'b0, bus.filter_ready}, 1);
    endtask
    task automatic send(input int kind, input logic [PB-1:0] d, input int gap);
        int t = 0;
        repeat (gap) begin
            @(negedge clk);
            chk("gap_ready_held", {31'b0, rdy(kind)}, 1);
        end
        if (kind == 0) begin bus.filter = d; bus.filter_valid = 1'b1; end
        else if (kind == 1) begin bus.ifmap = d; bus.ifmap_valid = 1'b1; end
        else begin bus.ipsum = d; bus.ipsum_valid = 1'b1; end
        while (!rdy(kind) && t < 300) begin @(negedge clk); t++; end
        chk("send_ready_timeout", {31'b0, t < 300}, 1);
        @(negedge clk);
        if (kind == 0) bus.filter_valid = 1'b0;
        else if (kind == 1) bus.ifmap_valid = 1'b0;
        else bus.ipsum_valid = 1'b0;
    endtask
    task automatic recv(input logic [PB-1:0] e, input int hold);
        int t = 0;
        bus.opsum_ready = 1'b0;
        while (!bus.opsum_valid && t < 500) begin @(negedge clk); t++; end
        chk("opsum_valid_timeout", {31'b0, t < 500}, 1);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, bus.opsum_valid}, 1);
            chk("hold_opsum", bus.opsum, e);
        end
        chk("opsum", bus.opsum, e);
        obs.push_back(bus.opsum);
        bus.opsum_ready = 1'b1;
        @(negedge clk);
        bus.opsum_ready = 1'b0;
    endtask
    task automatic run_job(input int fgap, input int hold, input bit rnd);
        int nfb = (dwn != 0) ? rsn : pn * rsn;
        int n   = (dwn != 0) ? qn : pn;
        int pos = 0;
        int f0;
        obs.delete();
        start_job();
        f0 = fcount;
        for (int b = 0; b < nfb; b++)
            send(0, fb[b], (b == fgap) ? 2 : rnd ? int'($urandom_range(0, 2)) : 0);
        // keep offering junk filter beats; none may be taken once loading is complete
        bus.filter = $urandom;
        bus.filter_valid = 1'b1;
        for (int col = 0; col <= fn; col++) begin
            for (int k = 0; k < ((col == 0) ? rsn : un); k++)
                send(1, xb[pos++], rnd ? int'($urandom_range(0, 1)) : 0);
            for (int j = 0; j < n; j++) send(2, ip[col][j], rnd ? int'($urandom_range(0, 1)) : 0);
            for (int j = 0; j < n; j++) recv(model(col, j), rnd ? int'($urandom_range(0, 2)) : hold);
            chk("done_after_col", {31'b0, bus.done}, (col == fn) ? 1 : 0);
            chk("busy_after_col", {31'b0, bus.busy}, (col == fn) ? 0 : 1);
        end
        bus.filter_valid = 1'b0;
        chk("filter_beats", fcount - f0, nfb);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, bus.done}, 0);
    endtask
    task automatic setup_t1();
        set_cfg(1, 1, 1, 1, 3, 0, 0, 128);
        fb[0] = 1; fb[1] = 2; fb[2] = 3;
        xb[0] = 129; xb[1] = 130; xb[2] = 131; xb[3] = 132;
        ip[0][0] = 10; ip[1][0] = 0;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 0);
        chk({tag, "_done"}, {31'b0, bus.done}, 0);
        chk({tag, "_readys"}, {29'b0, bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready}, 0);
        chk({tag, "_opsum_valid"}, {31'b0, bus.opsum_valid}, 0);
        chk({tag, "_opsum"}, bus.opsum, 0);
    endtask
    initial begin
        rst = 1'b1;
        bus.PE_en = 1'b0; bus.i_config = '0; bus.ifmap_zp = '0;
        bus.ifmap = '0; bus.filter = '0; bus.ipsum = '0;
        bus.ifmap_valid = 1'b0; bus.filter_valid = 1'b0; bus.ipsum_valid = 1'b0; bus.opsum_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");
        setup_t1();
        run_job(-1, 0, 1'b0);
        chk("single_row_col0", obs[0], 24);
        chk("single_row_col1", obs[1], 20);
        set_cfg(1, 1, 1, 2, 3, 0, 0, 128);
        fb[0] = 1; fb[1] = 2; fb[2] = 3;
        for (int i = 0; i < 5; i++) xb[i] = 129 + i;
        ip[0][0] = 0; ip[1][0] = 0;
        run_job(1, 0, 1'b0);
        chk("stride2_col0", obs[0], 14);
        chk("stride2_col1", obs[1], 26);
        set_cfg(2, 3, 0, 1, 2, 1, 0, 0);
        fb[0] = 32'h0000_0201; fb[1] = 32'h0000_0403;
        xb[0] = 32'h0000_0101; xb[1] = 32'h0000_0202;
        ip[0][0] = 0; ip[0][1] = 0;
        run_job(-1, 0, 1'b0);
        chk("depthwise_c0", obs[0], 7);
        chk("depthwise_c1", obs[1], 10);
        set_cfg(1, 2, 0, 1, 1, 0, 1, 0);
        fb[0] = 32'h0000_00FB; fb[1] = 32'h0000_0003; xb[0] = 32'h0000_0001;
        ip[0][0] = 0; ip[0][1] = 0;
        run_job(-1, 3, 1'b0);
        chk("relu_m0", obs[0], 0);
        chk("relu_m1", obs[1], 3);
        relun = 0;
        run_job(-1, 0, 1'b0);
        chk("norelu_m0", obs[0], 32'hFFFF_FFFB);
        chk("norelu_m1", obs[1], 3);
        set_cfg(4, 4, 0, 1, 4, 0, 0, 0);
        fill_rand();
        start_job();
        for (int b = 0; b < 16; b++) send(0, fb[b], 0);
        for (int b = 0; b < 4; b++) send(1, xb[b], 0);
        for (int j = 0; j < 4; j++) send(2, ip[0][j], 0);
        repeat (10) @(negedge clk);
        chk("conv_busy", {31'b0, bus.busy}, 1);
        chk("conv_no_valid", {31'b0, bus.opsum_valid}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_mid_conv");
        repeat (3) begin
            @(negedge clk);
            chk_idle("rst_after");
        end
        setup_t1();
        run_job(-1, 0, 1'b0);
        chk("rerun_col0", obs[0], 24);
        chk("rerun_col1", obs[1], 20);
        for (int it = 0; it < 24; it++) begin
            int rs = int'($urandom_range(1, 4));
            set_cfg(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                    int'($urandom_range(1, rs)), rs, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 255)));
            fill_rand();
            run_job(-1, 0, 1'b1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
